// File: rtl/dptr_pkg.sv
// ---------------------------------------------------------------------------
// dptr_pkg
// Definitions shared by the DPTR controller and the DPTR datapath:
//   - state_e   : controller FSM state encoding
//   - iclass_e  : decoded instruction class
//   - OP_* / FN_* : opcode (instr[31:26]) and R-type funct (instr[5:0]) values
//   - ALU_*     : alu_op codes driven to the datapath ALU
// Optional build macro used by the controller: DPTR_CTRL_MEMWAIT_EN
// ---------------------------------------------------------------------------
package dptr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CLS_R    = 2'd0,
        CLS_LW   = 2'd1,
        CLS_SW   = 2'd2,
        CLS_ADDI = 2'd3
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;

    // Classes that need a data-memory cycle after EXEC.
    function automatic logic is_mem_class(input iclass_e cls);
        return (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

endpackage

// File: rtl/dptr_decode.sv
// ---------------------------------------------------------------------------
// dptr_decode
// Purely combinational instruction decoder for the DPTR controller.
// Ports:
//   opcode_i [5:0] : instruction bits [31:26]
//   funct_i  [5:0] : instruction bits [5:0] (meaningful for R-type only)
//   cls_o          : instruction class (R / LW / SW / ADDI)
//   alu_op_o [2:0] : ALU operation for the EXEC cycle
//   valid_o        : 1 when opcode (and funct for R-type) is supported
// ---------------------------------------------------------------------------
module dptr_decode
    import dptr_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output iclass_e    cls_o,
    output logic [2:0] alu_op_o,
    output logic       valid_o
);

    always_comb begin
        cls_o    = CLS_R;
        alu_op_o = ALU_ADD;
        valid_o  = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                cls_o   = CLS_R;
                valid_o = 1'b1;
                case (funct_i)
                    FN_ADD:  alu_op_o = ALU_ADD;
                    FN_SUB:  alu_op_o = ALU_SUB;
                    FN_AND:  alu_op_o = ALU_AND;
                    FN_OR:   alu_op_o = ALU_OR;
                    FN_SLT:  alu_op_o = ALU_SLT;
                    default: valid_o  = 1'b0;
                endcase
            end
            // Loads, stores and ADDI all compute base + immediate.
            OP_LW: begin
                cls_o   = CLS_LW;
                valid_o = 1'b1;
            end
            OP_SW: begin
                cls_o   = CLS_SW;
                valid_o = 1'b1;
            end
            OP_ADDI: begin
                cls_o   = CLS_ADDI;
                valid_o = 1'b1;
            end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dptr_ctrl.sv
// ---------------------------------------------------------------------------
// dptr_ctrl
// Multi-cycle controller for the DPTR datapath: Moore FSM sequencing
// fetch / decode / execute / memory / write-back, plus a saturating
// completed-instruction counter.
//
// Build option: DPTR_CTRL_MEMWAIT_EN -- when defined, FETCH and MEM stall
// on mem_ready=0; when undefined, mem_ready is ignored (single-cycle memory).
//
// Ports:
//   clk, rst (async, active-high)
//   en          : run enable, sampled in IDLE and at instruction end
//   opcode/funct: fields of the datapath instruction register
//   mem_ready   : memory handshake (only with DPTR_CTRL_MEMWAIT_EN)
//   pc_we, ir_we, rf_we, alu_src_b, mem_re, mem_we, mem_to_reg : strobes
//   alu_op      : ALU operation (non-zero only in EXEC)
//   illegal     : sticky, set on entering HALT
//   instr_cnt   : saturating completed-instruction count
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for en
// FETCH  | read instruction memory, load IR, advance PC
// DECODE | classify IR contents, latch class and alu_op
// EXEC   | ALU operation; immediate operand for LW/SW/ADDI
// MEM    | data read (LW) or write (SW); SW ends here
// WB     | register-file write; ends R-type / ADDI / LW
// HALT   | undefined instruction seen; left only by reset
// ---------------------------------------------------------------------------
module dptr_ctrl
    import dptr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             alu_src_b,
    output logic             mem_re,
    output logic             mem_we,
    output logic             mem_to_reg,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    iclass_e          cls_q, cls_d;
    logic [2:0]       alu_q, alu_d;
    logic [CNT_W-1:0] cnt_q;
    logic             instr_end;
    logic             mem_ok;

    iclass_e          dec_cls;
    logic [2:0]       dec_alu;
    logic             dec_valid;

    dptr_decode u_decode (
        .opcode_i (opcode),
        .funct_i  (funct),
        .cls_o    (dec_cls),
        .alu_op_o (dec_alu),
        .valid_o  (dec_valid)
    );

`ifdef DPTR_CTRL_MEMWAIT_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cls_q   <= CLS_R;
            alu_q   <= ALU_ADD;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_d      = alu_q;
        instr_end  = 1'b0;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        rf_we      = 1'b0;
        alu_src_b  = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        alu_op     = ALU_ADD;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                // Read is held for the whole fetch; IR/PC update only once the
                // word is actually available, so a stalled fetch loads IR once.
                mem_re = 1'b1;
                if (mem_ok) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_valid) begin
                    cls_d   = dec_cls;
                    alu_d   = dec_alu;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_HALT;
                end
            end
            ST_EXEC: begin
                alu_op    = alu_q;
                alu_src_b = (cls_q != CLS_R);
                state_d   = is_mem_class(cls_q) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (cls_q == CLS_LW) mem_re = 1'b1;
                else                 mem_we = 1'b1;
                if (mem_ok) begin
                    if (cls_q == CLS_LW) state_d = ST_WB;
                    else                 instr_end = 1'b1;
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                mem_to_reg = (cls_q == CLS_LW);
                instr_end  = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase

        // en is only consulted here, so dropping it mid-instruction lets the
        // current instruction run to completion.
        if (instr_end) state_d = en ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (instr_end && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // HALT is absorbing until reset, so the flag is sticky by construction.
    assign illegal   = (state_q == ST_HALT);
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_dptr_ctrl.sv
module tb_dptr_ctrl;

    localparam logic [6:0] S_IDLE = 7'b0000000;  // {pc,ir,rf,srcb,re,we,m2r}
    localparam logic [6:0] S_F    = 7'b1100100;
    localparam logic [6:0] S_FW   = 7'b0000100;
    localparam logic [6:0] S_EI   = 7'b0001000;
    localparam logic [6:0] S_MR   = 7'b0000100;
    localparam logic [6:0] S_MW   = 7'b0000010;
    localparam logic [6:0] S_WR   = 7'b0010000;
    localparam logic [6:0] S_WL   = 7'b0010001;

    logic clk = 1'b0;
    logic rst, en, mem_ready;
    logic [5:0] opcode, funct;

    logic pc_we, ir_we, rf_we, alu_src_b, mem_re, mem_we, mem_to_reg, illegal;
    logic [2:0] alu_op;
    logic [15:0] instr_cnt;
    logic pc_we4, ir_we4, rf_we4, alu_src_b4, mem_re4, mem_we4, mem_to_reg4, illegal4;
    logic [2:0] alu_op4;
    logic [3:0] instr_cnt4;
    logic [6:0] strb, strb4;

    int n_chk  = 0;
    int n_pass = 0;

    logic [5:0] fn_tbl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [2:0] alu_tbl[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

    always #5 clk = ~clk;

    dptr_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
        .alu_src_b(alu_src_b), .mem_re(mem_re), .mem_we(mem_we),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .illegal(illegal),
        .instr_cnt(instr_cnt)
    );

    dptr_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_we(pc_we4), .ir_we(ir_we4), .rf_we(rf_we4),
        .alu_src_b(alu_src_b4), .mem_re(mem_re4), .mem_we(mem_we4),
        .mem_to_reg(mem_to_reg4), .alu_op(alu_op4), .illegal(illegal4),
        .instr_cnt(instr_cnt4)
    );

    assign strb  = {pc_we, ir_we, rf_we, alu_src_b, mem_re, mem_we, mem_to_reg};
    assign strb4 = {pc_we4, ir_we4, rf_we4, alu_src_b4, mem_re4, mem_we4, mem_to_reg4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [6:0] es, input logic [2:0] ea);
        tick();
        check({tag, "_strb"}, {25'd0, strb}, {25'd0, es});
        check({tag, "_alu"}, {29'd0, alu_op}, {29'd0, ea});
        check({tag, "_strb4"}, {25'd0, strb4}, {25'd0, es});
    endtask

    task automatic chk_cnt(input string tag, input int c16, input int c4);
        check({tag, "_cnt"}, {16'd0, instr_cnt}, c16);
        check({tag, "_cnt4"}, {28'd0, instr_cnt4}, c4);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_strb"}, {25'd0, strb}, 32'd0);
        check({tag, "_alu"}, {29'd0, alu_op}, 32'd0);
        check({tag, "_ill"}, {31'd0, illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; mem_ready = 1'b1;
        opcode = 6'h00; funct = 6'h20;

        // Reset held with en=1: no fetch may start.
        tick(); tick();
        chk_idle("rst");
        chk_cnt("rst", 0, 0);
        @(negedge clk) rst = 1'b0;
        #1 chk_idle("rst_rel");

        // R-type ADD: F D E W, rf_we in cycle 4
        step("add_f", S_F, 3'd0);
        step("add_d", S_IDLE, 3'd0);
        step("add_e", S_IDLE, 3'd0);
        step("add_w", S_WR, 3'd0);
        chk_cnt("add_w", 0, 0);
        opcode = 6'h23;

        // LW: F D E M W, mem_to_reg in cycle 5
        step("lw_f", S_F, 3'd0);
        chk_cnt("lw_f", 1, 1);
        step("lw_d", S_IDLE, 3'd0);
        step("lw_e", S_EI, 3'd0);
        step("lw_m", S_MR, 3'd0);
        step("lw_w", S_WL, 3'd0);
        opcode = 6'h2B;

        // SW: F D E M, mem_we in cycle 4, then idle
        step("sw_f", S_F, 3'd0);
        chk_cnt("sw_f", 2, 2);
        step("sw_d", S_IDLE, 3'd0);
        step("sw_e", S_EI, 3'd0);
        step("sw_m", S_MW, 3'd0);
        en = 1'b0;
        step("sw_end", S_IDLE, 3'd0);
        chk_cnt("sw_end", 3, 3);

        // ADDI with en dropped during EXEC
        opcode = 6'h08; en = 1'b1;
        step("addi_f", S_F, 3'd0);
        step("addi_d", S_IDLE, 3'd0);
        step("addi_e", S_EI, 3'd0);
        en = 1'b0;
        step("addi_w", S_WR, 3'd0);
        step("addi_i1", S_IDLE, 3'd0);
        chk_cnt("addi_i1", 4, 4);
        step("addi_i2", S_IDLE, 3'd0);
        chk_cnt("addi_i2", 4, 4);

`ifdef DPTR_CTRL_MEMWAIT_EN
        // Fetch stalls 3 cycles: mem_re held 4 cycles, one ir/pc pulse, 7-cycle R-type
        opcode = 6'h00; funct = 6'h20; en = 1'b1; mem_ready = 1'b0;
        step("mw_f1", S_FW, 3'd0);
        step("mw_f2", S_FW, 3'd0);
        step("mw_f3", S_FW, 3'd0);
        mem_ready = 1'b1;
        step("mw_f4", S_F, 3'd0);
        step("mw_d", S_IDLE, 3'd0);
        step("mw_e", S_IDLE, 3'd0);
        en = 1'b0;
        step("mw_w", S_WR, 3'd0);
        step("mw_end", S_IDLE, 3'd0);
        chk_cnt("mw_end", 5, 5);
`else
        // mem_ready low is ignored: LW still takes 5 cycles
        opcode = 6'h23; en = 1'b1; mem_ready = 1'b0;
        step("nw_f", S_F, 3'd0);
        step("nw_d", S_IDLE, 3'd0);
        step("nw_e", S_EI, 3'd0);
        step("nw_m", S_MR, 3'd0);
        en = 1'b0;
        step("nw_w", S_WL, 3'd0);
        step("nw_end", S_IDLE, 3'd0);
        chk_cnt("nw_end", 5, 5);
`endif
        mem_ready = 1'b1;

        // Clear counts, then 17 back-to-back R-types cycling through all funct codes
        @(negedge clk) rst = 1'b1;
        #1 chk_cnt("sat_rst", 0, 0);
        opcode = 6'h00; en = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            funct = fn_tbl[i % 5];
            step("sat_f", S_F, 3'd0);
            chk_cnt("sat_f", i, (i > 15) ? 15 : i);
            step("sat_d", S_IDLE, 3'd0);
            step("sat_e", S_IDLE, alu_tbl[i % 5]);
            if (i == 16) en = 1'b0;
            step("sat_w", S_WR, 3'd0);
        end
        step("sat_end", S_IDLE, 3'd0);
        chk_cnt("sat_end", 17, 15);

        // Undefined opcode -> HALT, sticky until reset
        opcode = 6'h3F; en = 1'b1;
        step("h_f", S_F, 3'd0);
        step("h_d", S_IDLE, 3'd0);
        step("h_halt", S_IDLE, 3'd0);
        check("h_ill", {31'd0, illegal}, 32'd1);
        check("h_ill4", {31'd0, illegal4}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            en = (i != 1);
            step("h_hold", S_IDLE, 3'd0);
            check("h_hold_ill", {31'd0, illegal}, 32'd1);
            chk_cnt("h_hold", 17, 15);
        end
        @(negedge clk) rst = 1'b1;
        #1 chk_idle("h_rst");
        chk_cnt("h_rst", 0, 0);

        // Undefined R-type funct -> HALT
        funct = 6'h01; opcode = 6'h00;
        @(negedge clk) rst = 1'b0;
        step("hf_f", S_F, 3'd0);
        step("hf_d", S_IDLE, 3'd0);
        step("hf_halt", S_IDLE, 3'd0);
        check("hf_ill", {31'd0, illegal}, 32'd1);
        @(negedge clk) rst = 1'b1;
        #1 check("hf_rst_ill", {31'd0, illegal}, 32'd0);

        // Reset asserted mid-LW (in MEM) clears outputs before the next edge
        opcode = 6'h23; funct = 6'h20;
        @(negedge clk) rst = 1'b0;
        step("rl_f", S_F, 3'd0);
        step("rl_d", S_IDLE, 3'd0);
        step("rl_e", S_EI, 3'd0);
        step("rl_m", S_MR, 3'd0);
        #2 rst = 1'b1;
        #1 chk_idle("rl_async");
        chk_cnt("rl_async", 0, 0);
        en = 1'b0;
        @(negedge clk) rst = 1'b0;
        step("rl_idle", S_IDLE, 3'd0);
        chk_cnt("rl_idle", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
